// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci engine and its binary-to-BCD display stage.
package fib_pkg;

   localparam int FIB_W      = 16;
   localparam int BCD_DIGITS = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } bcd_state_t;

   typedef logic [4*BCD_DIGITS-1:0] bcd_word_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj (
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);

   always_comb begin
      digit_o = digit_i;
      if (digit_i >= 4'd5) begin
         digit_o = digit_i + 4'd3;
      end
   end

endmodule

// File: rtl/fib_bcd_convert.sv
// Iterative binary-to-packed-BCD converter (shift-and-add-3), one input bit per
// clock, using the same start / done / busy handshake as the Fibonacci engine.
module fib_bcd_convert
   import fib_pkg::*;
#(
   parameter int BIN_W  = FIB_W,
   parameter int DIGITS = BCD_DIGITS
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [BIN_W-1:0]      din,
   input  logic                  start,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  done,
   output logic                  busy,
   output logic [1:0]            state_dbg
);

   // Handshake: a one-cycle start is accepted only while busy is low (IDLE),
   // din is captured on that same edge; done pulses for exactly one cycle when
   // bcd is refreshed, and bcd then holds until the next done.

   localparam int SR_W  = 4*DIGITS + BIN_W;
   localparam int CNT_W = $clog2(BIN_W) + 1;

   bcd_state_t            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [SR_W-1:0]       sr_q, sr_d;
   logic [4*DIGITS-1:0]   bcd_q, bcd_d;
   logic [4*DIGITS-1:0]   adj_digits;
   logic [SR_W-1:0]       adj_sr;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_i (sr_q[BIN_W + 4*g +: 4]),
         .digit_o (adj_digits[4*g +: 4])
      );
   end

   assign adj_sr = {adj_digits, sr_q[BIN_W-1:0]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      bcd_d   = bcd_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               sr_d    = {{(4*DIGITS){1'b0}}, din};
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sr_d  = adj_sr << 1;
            cnt_d = cnt_q + CNT_W'(1);
            // The last shift publishes the whole decimal field at once.
            if (cnt_q == CNT_W'(BIN_W - 1)) begin
               bcd_d   = sr_d[SR_W-1:BIN_W];
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         bcd_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         bcd_q   <= bcd_d;
      end
   end

   // Status flags decode straight from state so reset clears them immediately.
   assign bcd       = bcd_q;
   assign done      = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign state_dbg = state_q;

endmodule

// File: tb/tb_fib_bcd_convert.sv
// Directed bench for fib_bcd_convert: latency, hold, boundaries, ignored start,
// asynchronous reset and a Fibonacci-style upstream driver.
module tb_fib_bcd_convert;
   import fib_pkg::*;

   logic            clk;
   logic            reset;
   logic [15:0]     din;
   logic            start;
   logic [19:0]     bcd;
   logic            done;
   logic            busy;
   logic [1:0]      state_dbg;

   int vectors;
   int miscompares;

   fib_bcd_convert dut (
      .clk       (clk),
      .reset     (reset),
      .din       (din),
      .start     (start),
      .bcd       (bcd),
      .done      (done),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Every published result must be legal BCD.
   always @(negedge clk) begin
      if (reset && done) begin
         for (int d = 0; d < 5; d++) begin
            check("digit_le_9", {31'd0, (bcd[4*d +: 4] > 4'd9)}, 32'd0);
         end
      end
   end

   // Drives a one-cycle start from a negedge and follows the conversion until
   // busy drops. Cycle index 0 is the sample just after the accepting edge.
   task automatic convert(input logic [15:0] v, output int lat, output int busy_n,
                          output int done_n);
      din   = v;
      start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      din    = 16'($urandom);
      lat    = -1;
      busy_n = 0;
      done_n = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy) busy_n++;
         if (done) begin
            done_n++;
            if (lat < 0) lat = i;
         end
         if (!busy) break;
         @(negedge clk);
      end
   endtask

   initial begin : stim
      int lat, busy_n, done_n, changes;
      logic [19:0] held;
      vectors     = 0;
      miscompares = 0;
      reset = 1'b0;
      start = 1'b0;
      din   = '0;
      repeat (3) @(negedge clk);
      check("reset_bcd",   {12'd0, bcd}, 32'h0);
      check("reset_done",  {31'd0, done}, 32'd0);
      check("reset_busy",  {31'd0, busy}, 32'd0);
      check("reset_state", {30'd0, state_dbg}, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      convert(16'd5, lat, busy_n, done_n);
      check("d5_busy_cycles", busy_n, 17);
      check("d5_done_lat",    lat, 16);
      check("d5_done_count",  done_n, 1);
      check("d5_bcd",         {12'd0, bcd}, 32'h00005);

      convert(16'd4181, lat, busy_n, done_n);
      check("d4181_bcd", {12'd0, bcd}, 32'h04181);
      held    = 20'h04181;
      changes = 0;
      repeat (50) begin
         @(negedge clk);
         if (bcd !== held || done || busy) changes++;
      end
      check("d4181_hold", changes, 0);

      // Back-to-back: each new start goes out on the first cycle busy is low.
      convert(16'd0, lat, busy_n, done_n);
      check("d0_bcd",   {12'd0, bcd}, 32'h00000);
      check("d0_count", done_n, 1);
      convert(16'd65535, lat, busy_n, done_n);
      check("d65535_bcd", {12'd0, bcd}, 32'h65535);
      check("d65535_lat", lat, 16);
      convert(16'd144, lat, busy_n, done_n);
      check("d144_bcd", {12'd0, bcd}, 32'h00144);

      // Second start mid-conversion is dropped.
      din   = 16'd21;
      start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      done_n = 0;
      for (int i = 0; i < 40; i++) begin
         if (i == 4) begin
            din   = 16'd99;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (done) done_n++;
         @(negedge clk);
      end
      start = 1'b0;
      check("ignore_done_count", done_n, 1);
      check("ignore_bcd",        {12'd0, bcd}, 32'h00021);
      check("ignore_idle",       {31'd0, busy}, 32'd0);

      // Asynchronous reset at cycle 8 of a conversion.
      din   = 16'd12345;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      check("pre_rst_busy", {31'd0, busy}, 32'd1);
      #2 reset = 1'b0;
      #1;
      check("rst_async_bcd",  {12'd0, bcd}, 32'h0);
      check("rst_async_done", {31'd0, done}, 32'd0);
      check("rst_async_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      convert(16'd12345, lat, busy_n, done_n);
      check("d12345_bcd", {12'd0, bcd}, 32'h12345);
      check("d12345_lat", lat, 16);

      // Upstream Fibonacci engine stand-in: fib(3)=2, fib(8)=21, fib(12)=144,
      // each delivered as a dout value qualified by a one-cycle done.
      convert(16'd2, lat, busy_n, done_n);
      check("chain3_bcd", {12'd0, bcd}, 32'h00002);
      repeat (3) @(negedge clk);
      convert(16'd21, lat, busy_n, done_n);
      check("chain8_bcd", {12'd0, bcd}, 32'h00021);
      repeat (2) @(negedge clk);
      convert(16'd144, lat, busy_n, done_n);
      check("chain12_bcd", {12'd0, bcd}, 32'h00144);
      check("chain12_count", done_n, 1);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin : watchdog
      #200000;
      miscompares++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "timeout");
   end

endmodule
